// File: rtl/param_load_sched.sv
// -----------------------------------------------------------------------------
// param_load_sched
// Streams every CNN parameter word from one shared 32-bit source into the
// per-layer weight/bias loaders, in the order conv1..conv4, fc6, fc7.
// For each layer it sends all weight words, then all bias words, then one
// bubble cycle. Every accepted word is registered onto the shared weight or
// bias bus. Exactly one one-hot strobe bit rises one cycle after the accept.
//
// Optional feature: define PARAM_CHECKSUM_EN to enable a running modulo-2^BIT
// sum of every accepted word. When it is undefined, checksum is tied to 0.
//
// Ports:
//   clk, rst_        clock, asynchronous active-low reset
//   start            one-cycle pulse that begins a full load (ignored when busy)
//   abort            synchronous cancel; returns to IDLE on the next edge
//   src_data/valid   parameter word from memory
//   src_ready        word is accepted this cycle (valid & ready)
//   weight_bus       last accepted weight word (shared by all layers)
//   bias_bus         last accepted bias word (shared by all layers)
//   control_weight   one-hot weight strobe, bit i = layer i
//   control_bias     one-hot bias strobe, bit i = layer i
//   layer_idx        layer currently being loaded (0 when idle)
//   busy             high from the accepted start until the load completes
//   done             one-cycle pulse after the last word is delivered
//   checksum         running parameter checksum (0 unless PARAM_CHECKSUM_EN)
// -----------------------------------------------------------------------------
module param_load_sched #(
   parameter int                          BIT       = 32,
   parameter int                          NUM_LAYER = 6,
   parameter int                          CNT_W     = 16,
   parameter logic [NUM_LAYER*CNT_W-1:0]  W_LENS    = {NUM_LAYER{CNT_W'(2)}},
   parameter logic [NUM_LAYER*CNT_W-1:0]  B_LENS    = {NUM_LAYER{CNT_W'(1)}}
) (
   input  logic                 clk,
   input  logic                 rst_,
   input  logic                 start,
   input  logic                 abort,
   input  logic [BIT-1:0]       src_data,
   input  logic                 src_valid,
   output logic                 src_ready,
   output logic [BIT-1:0]       weight_bus,
   output logic [BIT-1:0]       bias_bus,
   output logic [NUM_LAYER-1:0] control_weight,
   output logic [NUM_LAYER-1:0] control_bias,
   output logic [2:0]           layer_idx,
   output logic                 busy,
   output logic                 done,
   output logic [BIT-1:0]       checksum
);

   typedef enum logic [2:0] {S_IDLE, S_WEIGHT, S_BIAS, S_NEXT, S_DONE} state_t;

   localparam logic [2:0]           LAST_LAYER = 3'(NUM_LAYER - 1);
   localparam logic [NUM_LAYER-1:0] ONE_HOT0   = NUM_LAYER'(1);

   state_t               state_q, state_d;
   logic [2:0]           layer_q, layer_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT-1:0]       wbus_q, wbus_d;
   logic [BIT-1:0]       bbus_q, bbus_d;
   logic [NUM_LAYER-1:0] cw_q, cw_d;
   logic [NUM_LAYER-1:0] cb_q, cb_d;
   logic                 busy_q, busy_d;
   logic                 accept;
   logic [CNT_W-1:0]     wlen, blen;

   function automatic logic [CNT_W-1:0] w_len(input logic [2:0] l);
      return W_LENS[int'(l)*CNT_W +: CNT_W];
   endfunction

   function automatic logic [CNT_W-1:0] b_len(input logic [2:0] l);
      return B_LENS[int'(l)*CNT_W +: CNT_W];
   endfunction

   // A layer with no weights starts in BIAS. A layer with no parameters at
   // all only gets its bubble cycle.
   function automatic state_t entry_state(input logic [2:0] l);
      if (w_len(l) != '0)      return S_WEIGHT;
      else if (b_len(l) != '0) return S_BIAS;
      else                     return S_NEXT;
   endfunction

   // abort masks ready so that a word offered alongside it is never consumed.
   assign src_ready = ((state_q == S_WEIGHT) || (state_q == S_BIAS)) && !abort;
   assign accept    = src_valid && src_ready;
   assign wlen      = w_len(layer_q);
   assign blen      = b_len(layer_q);

`ifdef PARAM_CHECKSUM_EN
   logic [BIT-1:0] csum_q, csum_d;
`endif

   always_comb begin
      state_d = state_q;
      layer_d = layer_q;
      cnt_d   = cnt_q;
      wbus_d  = wbus_q;
      bbus_d  = bbus_q;
      cw_d    = '0;
      cb_d    = '0;
      busy_d  = busy_q;
`ifdef PARAM_CHECKSUM_EN
      csum_d  = csum_q;
      if (accept) csum_d = csum_q + src_data;
`endif
      if (abort) begin
         state_d = S_IDLE;
         layer_d = '0;
         cnt_d   = '0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  layer_d = '0;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = entry_state(3'd0);
`ifdef PARAM_CHECKSUM_EN
                  csum_d  = '0;
`endif
               end
            end
            S_WEIGHT: begin
               if (accept) begin
                  wbus_d = src_data;
                  cw_d   = ONE_HOT0 << layer_q;
                  if (cnt_q == wlen - CNT_W'(1)) begin
                     cnt_d   = '0;
                     state_d = (blen == '0) ? S_NEXT : S_BIAS;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            S_BIAS: begin
               if (accept) begin
                  bbus_d = src_data;
                  cb_d   = ONE_HOT0 << layer_q;
                  if (cnt_q == blen - CNT_W'(1)) begin
                     cnt_d   = '0;
                     state_d = S_NEXT;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            S_NEXT: begin
               if (layer_q == LAST_LAYER) begin
                  state_d = S_DONE;
               end else begin
                  layer_d = layer_q + 3'd1;
                  state_d = entry_state(layer_q + 3'd1);
               end
            end
            S_DONE: begin
               busy_d  = 1'b0;
               layer_d = '0;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= S_IDLE;
         layer_q <= '0;
         cnt_q   <= '0;
         wbus_q  <= '0;
         bbus_q  <= '0;
         cw_q    <= '0;
         cb_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
         cnt_q   <= cnt_d;
         wbus_q  <= wbus_d;
         bbus_q  <= bbus_d;
         cw_q    <= cw_d;
         cb_q    <= cb_d;
         busy_q  <= busy_d;
      end
   end

`ifdef PARAM_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) csum_q <= '0;
      else       csum_q <= csum_d;
   end
   assign checksum = csum_q;
`else
   assign checksum = '0;
`endif

   assign weight_bus     = wbus_q;
   assign bias_bus       = bbus_q;
   assign control_weight = cw_q;
   assign control_bias   = cb_q;
   assign layer_idx      = layer_q;
   assign busy           = busy_q;
   assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_param_load_sched.sv
module tb_param_load_sched;

`ifdef PARAM_CHECKSUM_EN
   localparam bit CS_ON = 1'b1;
`else
   localparam bit CS_ON = 1'b0;
`endif

   logic        clk;
   logic        rst_;
   logic        st [3];
   logic        abort;
   logic [31:0] src_data;
   logic        src_valid;

   logic        rdy [3];
   logic [31:0] wb  [3];
   logic [31:0] bb  [3];
   logic [5:0]  cw  [3];
   logic [5:0]  cb  [3];
   logic [2:0]  li  [3];
   logic        bz  [3];
   logic        dn  [3];
   logic [31:0] cs  [3];

   int          total;
   int          bad;
   int          cfg_w [6];
   int          cfg_b [6];
   logic [31:0] wq [18];

   // DUT 0: every layer has 2 weights and 1 bias
   param_load_sched #(.BIT(32), .NUM_LAYER(6), .CNT_W(16),
      .W_LENS({16'd2,16'd2,16'd2,16'd2,16'd2,16'd2}),
      .B_LENS({16'd1,16'd1,16'd1,16'd1,16'd1,16'd1})) dut0 (
      .clk(clk), .rst_(rst_), .start(st[0]), .abort(abort),
      .src_data(src_data), .src_valid(src_valid), .src_ready(rdy[0]),
      .weight_bus(wb[0]), .bias_bus(bb[0]), .control_weight(cw[0]),
      .control_bias(cb[0]), .layer_idx(li[0]), .busy(bz[0]), .done(dn[0]),
      .checksum(cs[0]));

   // DUT 1: layer 2 has no weights, layer 4 has no bias
   param_load_sched #(.BIT(32), .NUM_LAYER(6), .CNT_W(16),
      .W_LENS({16'd2,16'd2,16'd2,16'd0,16'd2,16'd2}),
      .B_LENS({16'd1,16'd0,16'd1,16'd1,16'd1,16'd1})) dut1 (
      .clk(clk), .rst_(rst_), .start(st[1]), .abort(abort),
      .src_data(src_data), .src_valid(src_valid), .src_ready(rdy[1]),
      .weight_bus(wb[1]), .bias_bus(bb[1]), .control_weight(cw[1]),
      .control_bias(cb[1]), .layer_idx(li[1]), .busy(bz[1]), .done(dn[1]),
      .checksum(cs[1]));

   // DUT 2: only layer 0 carries one weight and one bias
   param_load_sched #(.BIT(32), .NUM_LAYER(6), .CNT_W(16),
      .W_LENS({16'd0,16'd0,16'd0,16'd0,16'd0,16'd1}),
      .B_LENS({16'd0,16'd0,16'd0,16'd0,16'd0,16'd1})) dut2 (
      .clk(clk), .rst_(rst_), .start(st[2]), .abort(abort),
      .src_data(src_data), .src_valid(src_valid), .src_ready(rdy[2]),
      .weight_bus(wb[2]), .bias_bus(bb[2]), .control_weight(cw[2]),
      .control_bias(cb[2]), .layer_idx(li[2]), .busy(bz[2]), .done(dn[2]),
      .checksum(cs[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input int s);
      chk("z_ready",  32'(rdy[s]), 32'd0);
      chk("z_wbus",   wb[s],       32'd0);
      chk("z_bbus",   bb[s],       32'd0);
      chk("z_strobe", 32'({cw[s], cb[s]}), 32'd0);
      chk("z_layer",  32'(li[s]),  32'd0);
      chk("z_busy",   32'(bz[s]),  32'd0);
      chk("z_done",   32'(dn[s]),  32'd0);
      chk("z_csum",   cs[s],       32'd0);
   endtask

   // One full (or cut-short) load on DUT s. Each layer takes its words and
   // then exactly one bubble cycle. The last bubble is followed by the done
   // cycle. A negative index disables the abort/restart/reset event.
   task automatic load(input int s, input bit stall, input int abort_at,
                       input int restart_at, input int reset_at,
                       input logic [31:0] exp_cs);
      int          wi;
      bit          stop;
      bit          isb;
      logic [31:0] wd;
      logic [31:0] exp_strobe;
      wi   = 0;
      stop = 1'b0;
      src_valid = 1'b0;
      st[s] = 1'b1;
      @(posedge clk); #1;
      st[s] = 1'b0;
      chk("start_busy", 32'(bz[s]), 32'd1);
      chk("start_done", 32'(dn[s]), 32'd0);
      for (int L = 0; L < 6 && !stop; L++) begin
         for (int k = 0; k < cfg_w[L] + cfg_b[L] && !stop; k++) begin
            isb = (k >= cfg_w[L]);
            if (stall) begin
               src_valid = 1'b0;
               src_data  = 32'h5555_AAAA;
               #1;
               chk("stall_ready", 32'(rdy[s]), 32'd1);
               @(posedge clk); #1;
               chk("stall_strobe", 32'({cw[s], cb[s]}), 32'd0);
               chk("stall_layer", 32'(li[s]), 32'(L));
            end
            wd = wq[wi];
            src_data  = wd;
            src_valid = 1'b1;
            if (wi == abort_at) begin
               abort = 1'b1;
               #1;
               chk("abort_ready", 32'(rdy[s]), 32'd0);
               @(posedge clk); #1;
               abort = 1'b0;
               chk("abort_strobe", 32'({cw[s], cb[s]}), 32'd0);
               chk("abort_busy",   32'(bz[s]), 32'd0);
               chk("abort_done",   32'(dn[s]), 32'd0);
               chk("abort_layer",  32'(li[s]), 32'd0);
               stop = 1'b1;
            end else begin
               if (wi == restart_at) st[s] = 1'b1;
               #1;
               chk("word_ready", 32'(rdy[s]), 32'd1);
               @(posedge clk); #1;
               st[s] = 1'b0;
               exp_strobe = isb ? (32'd1 << L) : (32'd1 << (L + 6));
               chk("word_strobe", 32'({cw[s], cb[s]}), exp_strobe);
               chk(isb ? "bias_bus" : "weight_bus", isb ? bb[s] : wb[s], wd);
               chk("word_layer", 32'(li[s]), 32'(L));
               chk("word_busy",  32'(bz[s]), 32'd1);
               wi++;
               if (wi == reset_at) begin
                  #2;
                  rst_ = 1'b0;
                  #1;
                  chk_zero(s);
                  stop = 1'b1;
               end
            end
         end
         if (!stop) begin
            src_valid = 1'b1;
            src_data  = 32'hDEAD_BEEF;
            #1;
            chk("bubble_ready", 32'(rdy[s]), 32'd0);
            chk("bubble_done",  32'(dn[s]), 32'd0);
            @(posedge clk); #1;
            chk("bubble_strobe", 32'({cw[s], cb[s]}), 32'd0);
         end
      end
      if (!stop) begin
         src_valid = 1'b0;
         chk("done_pulse", 32'(dn[s]), 32'd1);
         chk("done_busy",  32'(bz[s]), 32'd1);
         chk("done_ready", 32'(rdy[s]), 32'd0);
         @(posedge clk); #1;
         chk("after_done",  32'(dn[s]), 32'd0);
         chk("after_busy",  32'(bz[s]), 32'd0);
         chk("after_layer", 32'(li[s]), 32'd0);
         chk("csum", cs[s], CS_ON ? exp_cs : 32'd0);
      end
      src_valid = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_  = 1'b0;
      abort = 1'b0;
      src_data  = '0;
      src_valid = 1'b0;
      for (int i = 0; i < 3; i++) st[i] = 1'b0;

      // reset state
      @(posedge clk); @(posedge clk); #1;
      for (int i = 0; i < 3; i++) chk_zero(i);
      @(negedge clk);
      rst_ = 1'b1;
      @(posedge clk); #1;
      chk_zero(0);

      // test 1: 2 weights + 1 bias per layer, words 1..18, no stalls
      for (int i = 0; i < 6; i++) begin cfg_w[i] = 2; cfg_b[i] = 1; end
      for (int i = 0; i < 18; i++) wq[i] = 32'(i + 1);
      load(0, 1'b0, -1, -1, -1, 32'd171);

      // test 2: valid toggling, with a start pulse that lands while busy
      load(0, 1'b1, -1, 4, -1, 32'd171);

      // test 4: abort on the bias word of layer 3, then a fresh full load
      load(0, 1'b0, 11, -1, -1, 32'd0);
      chk("abort_csum_hold", cs[0], CS_ON ? 32'd66 : 32'd0);
      @(posedge clk); #1;
      chk("abort_no_done", 32'(dn[0]), 32'd0);
      chk("abort_idle_ready", 32'(rdy[0]), 32'd0);
      load(0, 1'b0, -1, -1, -1, 32'd171);

      // test 5: asynchronous reset right after a layer-1 weight accept
      load(0, 1'b0, -1, -1, 4, 32'd0);
      @(negedge clk);
      rst_ = 1'b1;
      @(posedge clk); #1;
      chk_zero(0);

      // test 3: layer 2 without weights, layer 4 without bias
      cfg_w[2] = 0;
      cfg_b[4] = 0;
      for (int i = 0; i < 15; i++) wq[i] = 32'(i + 1);
      load(1, 1'b0, -1, -1, -1, 32'd120);

      // test 6: checksum wraps modulo 2^32
      for (int i = 0; i < 6; i++) begin cfg_w[i] = 0; cfg_b[i] = 0; end
      cfg_w[0] = 1;
      cfg_b[0] = 1;
      wq[0] = 32'hFFFF_FFFF;
      wq[1] = 32'h0000_0002;
      load(2, 1'b0, -1, -1, -1, 32'h0000_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
